// File: rtl/tinyml_display_dma_sched.sv
// ----------------------------------------------------------------------------
// tinyml_display_dma_sched
// Frame-level read scheduler for the display DMA path. On each display frame
// start (vs_fall) it picks the newest completed frame buffer, then issues burst
// read commands to the DMA engine. A burst is only issued when the display FIFO
// can hold it together with all words already requested but not yet delivered.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   enable            scheduler runs while high
//   vs_fall           1-cycle pulse, display frame start
//   wr_buf_done/idx   writer finished buffer wr_buf_idx
//   fifo_level        display FIFO occupancy in words
//   data_beat         one read word accepted into the display path
//   cmd_valid/ready   read command handshake
//   cmd_addr/cmd_len  burst start byte address / burst length minus 1
//   rd_buf_idx        buffer currently being read
//   frame_active      high from frame start until the last word arrives
//   frame_done        1-cycle pulse after the last word of a frame
//   late_frame        sticky: frame start seen while a frame was active
//   late_count        saturating count of such late frame starts
// ----------------------------------------------------------------------------
module tinyml_display_dma_sched #(
    parameter int                FRAME_WIDTH  = 640,
    parameter int                FRAME_HEIGHT = 480,
    parameter int                BURST_WORDS  = 64,
    parameter int                FIFO_DEPTH   = 1024,
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] BUF_BASE     = 32'h0100_0000,
    parameter logic [ADDR_W-1:0] BUF_STRIDE   = 32'h0010_0000,
    localparam int               LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              vs_fall,
    input  logic              wr_buf_done,
    input  logic [1:0]        wr_buf_idx,
    input  logic [LVL_W-1:0]  fifo_level,
    input  logic              data_beat,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [7:0]        cmd_len,
    output logic [1:0]        rd_buf_idx,
    output logic              frame_active,
    output logic              frame_done,
    output logic              late_frame,
    output logic [15:0]       late_count
);
    localparam int WORDS = FRAME_WIDTH * FRAME_HEIGHT / 2;
    localparam int CW    = $clog2(WORDS) + 1;

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_CREDIT, S_BURST, S_DRAIN} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [CW-1:0]     r_remaining;
    logic [CW-1:0]     r_outstanding;
    logic [8:0]        r_burst;        // words in the pending burst (1..256)
    logic [7:0]        r_len_m1;
    logic [1:0]        r_latest;
    logic              r_new_avail;
    logic [1:0]        r_rd_idx;
    logic              r_frame_active;
    logic              r_frame_done;
    logic              r_late_frame;
    logic [15:0]       r_late_count;

    logic [8:0]        w_len;
    logic [31:0]       w_need;
    logic              w_credit_ok;
    logic              w_start;
    logic              w_handshake;
    logic              w_drain_done;
    logic              w_late;
    logic [1:0]        w_sel_idx;
    logic [CW-1:0]     w_inc;
    logic [CW-1:0]     w_dec;

    always_comb begin
        if (32'(r_remaining) < 32'(BURST_WORDS)) w_len = 9'(r_remaining);
        else                                     w_len = 9'(BURST_WORDS);
    end

    // Credit counts words already requested but not yet delivered, so the
    // FIFO can never be overrun by data that is still in flight.
    assign w_need       = 32'(fifo_level) + 32'(r_outstanding) + 32'(w_len);
    assign w_credit_ok  = (w_need <= 32'(FIFO_DEPTH));
    assign w_start      = (r_state == S_ARM) && enable && vs_fall;
    assign w_handshake  = (r_state == S_BURST) && cmd_ready;
    assign w_drain_done = (r_state == S_DRAIN) && (r_outstanding == '0);
    assign w_late       = vs_fall && ((r_state == S_CREDIT) || (r_state == S_BURST) ||
                                      (r_state == S_DRAIN));
    // A completion arriving in the same cycle as the frame start wins.
    assign w_sel_idx    = wr_buf_done ? wr_buf_idx : (r_new_avail ? r_latest : r_rd_idx);
    assign w_inc        = w_handshake ? CW'(r_burst) : '0;
    // Beats with nothing outstanding are ignored so the counter never wraps.
    assign w_dec        = (data_beat && (r_outstanding != '0)) ? CW'(1) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        cmd_valid    = 1'b0;
        case (r_state)
            S_IDLE:   if (enable) w_state_next = S_ARM;
            S_ARM: begin
                if (!enable)      w_state_next = S_IDLE;
                else if (vs_fall) w_state_next = S_CREDIT;
            end
            S_CREDIT: if (w_credit_ok) w_state_next = S_BURST;
            S_BURST: begin
                cmd_valid = 1'b1;
                if (cmd_ready)
                    w_state_next = (32'(r_remaining) > 32'(r_burst)) ? S_CREDIT : S_DRAIN;
            end
            S_DRAIN:  if (r_outstanding == '0) w_state_next = S_ARM;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr         <= '0;
            r_remaining    <= '0;
            r_outstanding  <= '0;
            r_burst        <= '0;
            r_len_m1       <= '0;
            r_latest       <= '0;
            r_new_avail    <= 1'b0;
            r_rd_idx       <= '0;
            r_frame_active <= 1'b0;
            r_frame_done   <= 1'b0;
            r_late_frame   <= 1'b0;
            r_late_count   <= '0;
        end else begin
            if (wr_buf_done) r_latest <= wr_buf_idx;

            if (w_start) begin
                r_new_avail    <= 1'b0;
                r_rd_idx       <= w_sel_idx;
                r_addr         <= BUF_BASE + ADDR_W'(w_sel_idx) * BUF_STRIDE;
                r_remaining    <= CW'(WORDS);
                r_frame_active <= 1'b1;
            end else if (wr_buf_done) begin
                r_new_avail    <= 1'b1;
            end

            if ((r_state == S_CREDIT) && w_credit_ok) begin
                r_burst  <= w_len;
                r_len_m1 <= 8'(w_len - 9'd1);
            end

            if (w_handshake) begin
                r_addr      <= r_addr + (ADDR_W'(r_burst) << 3);
                r_remaining <= r_remaining - CW'(r_burst);
            end

            r_outstanding <= r_outstanding + w_inc - w_dec;

            r_frame_done <= w_drain_done;
            if (w_drain_done) r_frame_active <= 1'b0;

            if (w_late) begin
                r_late_frame <= 1'b1;
                if (r_late_count != 16'hFFFF) r_late_count <= r_late_count + 16'd1;
            end
        end
    end

    assign cmd_addr     = r_addr;
    assign cmd_len      = r_len_m1;
    assign rd_buf_idx   = r_rd_idx;
    assign frame_active = r_frame_active;
    assign frame_done   = r_frame_done;
    assign late_frame   = r_late_frame;
    assign late_count   = r_late_count;
endmodule

// File: tb/tb_tinyml_display_dma_sched.sv
module tb_tinyml_display_dma_sched;
    // Main instance uses a reduced frame (64x8 -> 256 words, 4 bursts of 64)
    // so a full frame of data beats fits in a short run; FIFO/burst/buffer
    // parameters keep their defaults.
    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, vs_fall, wr_buf_done, data_beat, cmd_ready;
    logic [1:0]  wr_buf_idx;
    logic [10:0] fifo_level;
    logic        cmd_valid, frame_active, frame_done, late_frame;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [1:0]  rd_buf_idx;
    logic [15:0] late_count;

    // Small instance: 10x3 frame -> 15 words, bursts of 4.
    logic        s_enable, s_vs_fall, s_data_beat;
    logic        s_cmd_valid, s_frame_active, s_frame_done, s_late_frame;
    logic [31:0] s_cmd_addr;
    logic [7:0]  s_cmd_len;
    logic [1:0]  s_rd_buf_idx;
    logic [15:0] s_late_count;

    always #5 clk = ~clk;

    tinyml_display_dma_sched #(.FRAME_WIDTH(64), .FRAME_HEIGHT(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .vs_fall(vs_fall),
        .wr_buf_done(wr_buf_done), .wr_buf_idx(wr_buf_idx), .fifo_level(fifo_level),
        .data_beat(data_beat), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .rd_buf_idx(rd_buf_idx),
        .frame_active(frame_active), .frame_done(frame_done),
        .late_frame(late_frame), .late_count(late_count));

    tinyml_display_dma_sched #(.FRAME_WIDTH(10), .FRAME_HEIGHT(3), .BURST_WORDS(4)) u_small (
        .clk(clk), .rst_n(rst_n), .enable(s_enable), .vs_fall(s_vs_fall),
        .wr_buf_done(1'b0), .wr_buf_idx(2'd0), .fifo_level(11'd0),
        .data_beat(s_data_beat), .cmd_valid(s_cmd_valid), .cmd_ready(1'b1),
        .cmd_addr(s_cmd_addr), .cmd_len(s_cmd_len), .rd_buf_idx(s_rd_buf_idx),
        .frame_active(s_frame_active), .frame_done(s_frame_done),
        .late_frame(s_late_frame), .late_count(s_late_count));

    typedef struct { logic [31:0] addr; logic [7:0] len; } cmd_t;
    cmd_t       exp_q[$];
    cmd_t       s_exp_q[$];
    logic [1:0] fd_q[$];
    logic [1:0] s_fd_q[$];

    int checks = 0;
    int errors = 0;
    int issued = 0, sent = 0, s_issued = 0, s_sent = 0;
    logic beat_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [1:0] idx);
        cmd_t c;
        for (int k = 0; k < 4; k++) begin
            c.addr = 32'h0100_0000 + 32'(idx) * 32'h0010_0000 + 32'(k) * 32'd512;
            c.len  = 8'd63;
            exp_q.push_back(c);
        end
        fd_q.push_back(idx);
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && fd_q.size() == 0 &&
                s_exp_q.size() == 0 && s_fd_q.size() == 0) break;
            step();
        end
        if (exp_q.size() != 0 || fd_q.size() != 0 || s_exp_q.size() != 0 || s_fd_q.size() != 0)
            fail_now(name);
    endtask

    // Scoreboard monitor, main instance.
    always @(negedge clk) begin
        cmd_t e;
        logic [1:0] fi;
        if (!rst_n) begin
            exp_q.delete();
            fd_q.delete();
            issued = 0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                if (exp_q.size() == 0) fail_now("unexpected_cmd");
                else begin
                    e = exp_q.pop_front();
                    $display("cmd addr=%08h len=%0d", cmd_addr, cmd_len);
                    chk("cmd_addr", 64'(cmd_addr), 64'(e.addr));
                    chk("cmd_len", 64'(cmd_len), 64'(e.len));
                    issued = issued + int'(e.len) + 1;
                end
            end
            if (frame_done) begin
                if (fd_q.size() == 0) fail_now("unexpected_frame_done");
                else begin
                    fi = fd_q.pop_front();
                    $display("frame_done buf=%0d", rd_buf_idx);
                    chk("frame_buf", 64'(rd_buf_idx), 64'(fi));
                    chk("frame_active_clear", 64'(frame_active), 64'd0);
                end
            end
        end
    end

    // Scoreboard monitor, small instance.
    always @(negedge clk) begin
        cmd_t e;
        logic [1:0] fi;
        if (!rst_n) begin
            s_issued = 0;
        end else begin
            if (s_cmd_valid) begin
                if (s_exp_q.size() == 0) fail_now("small_unexpected_cmd");
                else begin
                    e = s_exp_q.pop_front();
                    $display("small cmd addr=%08h len=%0d", s_cmd_addr, s_cmd_len);
                    chk("small_cmd_addr", 64'(s_cmd_addr), 64'(e.addr));
                    chk("small_cmd_len", 64'(s_cmd_len), 64'(e.len));
                    s_issued = s_issued + int'(e.len) + 1;
                end
            end
            if (s_frame_done) begin
                if (s_fd_q.size() == 0) fail_now("small_unexpected_frame_done");
                else begin
                    fi = s_fd_q.pop_front();
                    $display("small frame_done buf=%0d", s_rd_buf_idx);
                    chk("small_frame_buf", 64'(s_rd_buf_idx), 64'(fi));
                end
            end
        end
    end

    // Data return: one word per cycle for every word the bench saw requested.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            sent = 0; s_sent = 0; data_beat = 1'b0; s_data_beat = 1'b0;
        end else begin
            if (beat_en && issued > sent) begin data_beat = 1'b1; sent++; end
            else data_beat = 1'b0;
            if (s_issued > s_sent) begin s_data_beat = 1'b1; s_sent++; end
            else s_data_beat = 1'b0;
        end
    end

    initial begin
        cmd_t c;
        logic any_valid;
        rst_n = 1'b0; enable = 1'b0; vs_fall = 1'b0; wr_buf_done = 1'b0; wr_buf_idx = 2'd0;
        fifo_level = 11'd0; cmd_ready = 1'b1; s_enable = 1'b0; s_vs_fall = 1'b0;
        data_beat = 1'b0; s_data_beat = 1'b0;
        repeat (3) step();
        chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("rst_cmd_addr", 64'(cmd_addr), 64'd0);
        chk("rst_misc", {cmd_len, rd_buf_idx, frame_active, frame_done, late_frame, late_count},
            64'd0);
        rst_n = 1'b1;
        beat_en = 1'b1;

        // Short frame: 15 words in bursts of 4 -> lengths 3,3,3,2.
        s_enable = 1'b1;
        step(); step();
        for (int k = 0; k < 4; k++) begin
            c.addr = 32'h0100_0000 + 32'(k) * 32'd32;
            c.len  = (k == 3) ? 8'd2 : 8'd3;
            s_exp_q.push_back(c);
        end
        s_fd_q.push_back(2'd0);
        s_vs_fall = 1'b1; step(); s_vs_fall = 1'b0;
        wait_done("small_frame_timeout", 300);

        // Frame 1: buffer 2, free-running credit, first command within 2 cycles.
        enable = 1'b1;
        step(); step();
        wr_buf_idx = 2'd2; wr_buf_done = 1'b1; step(); wr_buf_done = 1'b0;
        push_frame(2'd2);
        vs_fall = 1'b1; step(); vs_fall = 1'b0;
        step();
        chk("start_latency_valid", 64'(cmd_valid), 64'd1);
        wait_done("frame1_timeout", 2000);
        chk("no_late_yet", 64'(late_frame), 64'd0);

        // Frame 2: no new buffer -> repeat 2; credit blocked at 980, stalled DMA.
        fifo_level = 11'd980; cmd_ready = 1'b0;
        push_frame(2'd2);
        vs_fall = 1'b1; step(); vs_fall = 1'b0;
        any_valid = 1'b0;
        repeat (8) begin step(); any_valid = any_valid | cmd_valid; end
        chk("credit_block", 64'(any_valid), 64'd0);
        chk("repeat_buf", 64'(rd_buf_idx), 64'd2);
        fifo_level = 11'd960;
        step();
        chk("credit_release", 64'(cmd_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", 64'(cmd_valid), 64'd1);
            chk("stall_addr", 64'(cmd_addr), 64'h0120_0000);
            chk("stall_len", 64'(cmd_len), 64'd63);
            step();
        end
        cmd_ready = 1'b1; fifo_level = 11'd0;
        wait_done("frame2_timeout", 2000);

        // Frame 3: completion coincident with frame start; late start in DRAIN.
        beat_en = 1'b0;
        push_frame(2'd3);
        wr_buf_idx = 2'd3; wr_buf_done = 1'b1; vs_fall = 1'b1;
        step();
        wr_buf_done = 1'b0; vs_fall = 1'b0;
        step();
        chk("coincident_buf", 64'(rd_buf_idx), 64'd3);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
        step(); step();
        chk("drain_active", 64'(frame_active), 64'd1);
        vs_fall = 1'b1; step(); vs_fall = 1'b0;
        chk("late_frame", 64'(late_frame), 64'd1);
        chk("late_count", 64'(late_count), 64'd1);
        beat_en = 1'b1;
        wait_done("frame3_timeout", 2000);
        any_valid = 1'b0;
        repeat (20) begin step(); any_valid = any_valid | cmd_valid; end
        chk("no_cmd_after_late", 64'(any_valid), 64'd0);
        push_frame(2'd3);
        vs_fall = 1'b1; step(); vs_fall = 1'b0;
        wait_done("frame4_timeout", 2000);
        chk("late_count_hold", 64'(late_count), 64'd1);

        // Reset while a command is waiting for the DMA.
        wr_buf_idx = 2'd1; wr_buf_done = 1'b1; step(); wr_buf_done = 1'b0;
        cmd_ready = 1'b0;
        vs_fall = 1'b1; step(); vs_fall = 1'b0;
        step();
        chk("pre_reset_valid", 64'(cmd_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(cmd_valid), 64'd0);
        chk("async_rst_addr", 64'(cmd_addr), 64'd0);
        chk("async_rst_misc", {cmd_len, rd_buf_idx, frame_active, frame_done, late_frame,
            late_count}, 64'd0);
        step(); step();
        rst_n = 1'b1; cmd_ready = 1'b1;
        repeat (3) step();
        chk("post_rst_idle", 64'(cmd_valid), 64'd0);
        push_frame(2'd0);
        vs_fall = 1'b1; step(); vs_fall = 1'b0;
        wait_done("post_reset_timeout", 2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
